// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command/register controller.
package spi_ctrl_pkg;

    localparam int NUM_REGS = 64;
    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 6;
    localparam int LEN_W    = 9;
    localparam int FLAT_W   = NUM_REGS * WORD_W;

    localparam int RNW_BIT  = 15;
    localparam int ADDR_HI  = 14;
    localparam int ADDR_LO  = 9;
    localparam int LEN_HI   = 8;
    localparam int LEN_LO   = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Register i of a flattened bank lives at bits [16i+15:16i].
    function automatic logic [WORD_W-1:0] bank_word(input logic [FLAT_W-1:0] flat,
                                                    input logic [ADDR_W-1:0] idx);
        return flat[{idx, 4'h0} +: WORD_W];
    endfunction

endpackage

// File: rtl/spi_burst_ptr.sv
// Burst address pointer (wraps over the bank) and remaining-word counter.
module spi_burst_ptr
    import spi_ctrl_pkg::*;
(
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_ptr,
    input  logic [LEN_W-1:0]  load_cnt,
    input  logic              step,
    input  logic              dec,
    output logic [ADDR_W-1:0] ptr,
    output logic              cnt_zero
);

    logic [ADDR_W-1:0] ptr_r;
    logic [LEN_W-1:0]  cnt_r;

    // Pointer and counter update; load has priority over step/decrement.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            ptr_r <= {ADDR_W{1'b0}};
            cnt_r <= {LEN_W{1'b0}};
        end else if (load) begin
            ptr_r <= load_ptr;
            cnt_r <= load_cnt;
        end else begin
            if (step) begin
                ptr_r <= ptr_r + 6'd1;
            end else begin
                ptr_r <= ptr_r;
            end
            if (dec) begin
                cnt_r <= cnt_r - 9'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign ptr      = ptr_r;
    assign cnt_zero = (cnt_r == 9'd0);

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI word command decoder, command-bank burst writer and data-bank readback sequencer.
// Optional build macro SPI_REG_CTRL_WRITE_ECHO_EN echoes accepted write data onto TX_WORD.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
(
    input  logic                SYS_CLK,
    input  logic                SYS_RST,
    input  logic                FRAME_ACTIVE,
    input  logic                RX_VALID,
    input  logic [WORD_W-1:0]   RX_WORD,
    output logic [WORD_W-1:0]   TX_WORD,
    input  logic [FLAT_W-1:0]   DATA_FLAT,
    output logic [FLAT_W-1:0]   CMD_FLAT,
    output logic [NUM_REGS-1:0] CMD_STROBE,
    output logic                ERR,
    input  logic                ERR_CLR
);

    state_t              state_r;
    logic [WORD_W-1:0]   tx_word_r;
    logic [FLAT_W-1:0]   cmd_flat_r;
    logic [NUM_REGS-1:0] cmd_strobe_r;
    logic                err_r;

    logic [ADDR_W-1:0]   ptr_s;
    logic                cnt_zero_s;
    logic                cmd_rnw_s;
    logic [ADDR_W-1:0]   cmd_addr_s;
    logic [LEN_W-1:0]    cmd_len_s;
    logic [ADDR_W-1:0]   load_ptr_s;
    logic                accept_s;
    logic                load_s;
    logic                step_s;
    logic                dec_s;
    logic                err_set_s;

    assign cmd_rnw_s  = RX_WORD[RNW_BIT];
    assign cmd_addr_s = RX_WORD[ADDR_HI:ADDR_LO];
    assign cmd_len_s  = RX_WORD[LEN_HI:LEN_LO];
    // A word arriving as the frame ends is dropped, so acceptance needs both.
    assign accept_s   = FRAME_ACTIVE & RX_VALID;

    spi_burst_ptr u_burst_ptr (
        .SYS_CLK  (SYS_CLK),
        .SYS_RST  (SYS_RST),
        .load     (load_s),
        .load_ptr (load_ptr_s),
        .load_cnt (cmd_len_s),
        .step     (step_s),
        .dec      (dec_s),
        .ptr      (ptr_s),
        .cnt_zero (cnt_zero_s)
    );

    // Pointer/counter control and error detection for the current cycle.
    always_comb begin
        load_s     = 1'b0;
        step_s     = 1'b0;
        dec_s      = 1'b0;
        load_ptr_s = cmd_addr_s;
        err_set_s  = 1'b0;
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    load_s     = 1'b1;
                    // Reads prefetch the first word on the command edge, so skip past it.
                    load_ptr_s = cmd_rnw_s ? (cmd_addr_s + 6'd1) : cmd_addr_s;
                end
                WR_DATA: begin
                    step_s = 1'b1;
                    dec_s  = ~cnt_zero_s;
                end
                RD_DATA: begin
                    step_s = ~cnt_zero_s;
                    dec_s  = ~cnt_zero_s;
                end
                DRAIN: begin
                    err_set_s = 1'b1;
                end
                default: begin
                    load_s = 1'b0;
                end
            endcase
        end else if (!FRAME_ACTIVE) begin
            err_set_s = ((state_r == WR_DATA) || (state_r == RD_DATA)) && !cnt_zero_s;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Main state machine with registered TX word, command bank and strobes.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_r      <= IDLE;
            tx_word_r    <= 16'h0000;
            cmd_flat_r   <= {FLAT_W{1'b0}};
            cmd_strobe_r <= {NUM_REGS{1'b0}};
            err_r        <= 1'b0;
        end else begin
            cmd_strobe_r <= {NUM_REGS{1'b0}};

            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (ERR_CLR) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end

            if (!FRAME_ACTIVE) begin
                state_r   <= IDLE;
                tx_word_r <= 16'h0000;
            end else if (RX_VALID) begin
                case (state_r)
                    IDLE: begin
                        if (cmd_rnw_s) begin
                            state_r   <= RD_DATA;
                            tx_word_r <= bank_word(DATA_FLAT, cmd_addr_s);
                        end else begin
                            state_r   <= WR_DATA;
                            tx_word_r <= 16'h0000;
                        end
                    end
                    WR_DATA: begin
                        cmd_flat_r[{ptr_s, 4'h0} +: WORD_W] <= RX_WORD;
                        cmd_strobe_r[ptr_s]                  <= 1'b1;
`ifdef SPI_REG_CTRL_WRITE_ECHO_EN
                        tx_word_r <= RX_WORD;
`else
                        tx_word_r <= 16'h0000;
`endif
                        state_r <= cnt_zero_s ? DRAIN : WR_DATA;
                    end
                    RD_DATA: begin
                        if (cnt_zero_s) begin
                            tx_word_r <= 16'h0000;
                            state_r   <= DRAIN;
                        end else begin
                            tx_word_r <= bank_word(DATA_FLAT, ptr_s);
                            state_r   <= RD_DATA;
                        end
                    end
                    DRAIN: begin
                        tx_word_r <= 16'h0000;
                        state_r   <= DRAIN;
                    end
                    default: begin
                        tx_word_r <= 16'h0000;
                        state_r   <= IDLE;
                    end
                endcase
            end else begin
                state_r   <= state_r;
                tx_word_r <= tx_word_r;
            end
        end
    end

    assign TX_WORD    = tx_word_r;
    assign CMD_FLAT   = cmd_flat_r;
    assign CMD_STROBE = cmd_strobe_r;
    assign ERR        = err_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl (inputs driven and outputs sampled on negedge).
module tb_spi_reg_ctrl;

    logic          SYS_CLK;
    logic          SYS_RST;
    logic          FRAME_ACTIVE;
    logic          RX_VALID;
    logic [15:0]   RX_WORD;
    logic [15:0]   TX_WORD;
    logic [1023:0] DATA_FLAT;
    logic [1023:0] CMD_FLAT;
    logic [63:0]   CMD_STROBE;
    logic          ERR;
    logic          ERR_CLR;

    int n_checks = 0;
    int n_errors = 0;
    logic [1023:0] exp_cmd;

    spi_reg_ctrl dut (
        .SYS_CLK      (SYS_CLK),
        .SYS_RST      (SYS_RST),
        .FRAME_ACTIVE (FRAME_ACTIVE),
        .RX_VALID     (RX_VALID),
        .RX_WORD      (RX_WORD),
        .TX_WORD      (TX_WORD),
        .DATA_FLAT    (DATA_FLAT),
        .CMD_FLAT     (CMD_FLAT),
        .CMD_STROBE   (CMD_STROBE),
        .ERR          (ERR),
        .ERR_CLR      (ERR_CLR)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        @(negedge SYS_CLK);
        RX_VALID = 1'b1;
        RX_WORD  = w;
        @(negedge SYS_CLK);
        RX_VALID = 1'b0;
        RX_WORD  = 16'h0000;
    endtask

    task automatic start_frame();
        @(negedge SYS_CLK);
        FRAME_ACTIVE = 1'b1;
    endtask

    task automatic end_frame();
        @(negedge SYS_CLK);
        FRAME_ACTIVE = 1'b0;
        @(negedge SYS_CLK);
    endtask

    task automatic clear_err();
        @(negedge SYS_CLK);
        ERR_CLR = 1'b1;
        @(negedge SYS_CLK);
        ERR_CLR = 1'b0;
    endtask

    initial begin
        SYS_RST      = 1'b1;
        FRAME_ACTIVE = 1'b0;
        RX_VALID     = 1'b0;
        RX_WORD      = 16'h0000;
        ERR_CLR      = 1'b0;
        DATA_FLAT    = '0;
        exp_cmd      = '0;
        repeat (3) @(negedge SYS_CLK);
        SYS_RST = 1'b0;
        @(negedge SYS_CLK);

        check("rst_tx", TX_WORD, 16'h0000);
        check("rst_cmd", CMD_FLAT, exp_cmd);
        check("rst_strobe", CMD_STROBE, 64'h0);
        check("rst_err", ERR, 1'b0);

        // 1: write burst of two words at address 5
        start_frame();
        send_word(16'h0A01);
        check("t1_tx_cmd", TX_WORD, 16'h0000);
        send_word(16'h1234);
        exp_cmd[5*16 +: 16] = 16'h1234;
        check("t1_strobe5", CMD_STROBE, 64'h0000_0000_0000_0020);
        check("t1_reg5", CMD_FLAT[5*16 +: 16], 16'h1234);
`ifdef SPI_REG_CTRL_WRITE_ECHO_EN
        check("t1_echo", TX_WORD, 16'h1234);
`else
        check("t1_tx_wr", TX_WORD, 16'h0000);
`endif
        send_word(16'hABCD);
        exp_cmd[6*16 +: 16] = 16'hABCD;
        check("t1_strobe6", CMD_STROBE, 64'h0000_0000_0000_0040);
        @(negedge SYS_CLK);
        check("t1_strobe_off", CMD_STROBE, 64'h0);
        check("t1_cmd", CMD_FLAT, exp_cmd);
        end_frame();
        check("t1_err", ERR, 1'b0);
        check("t1_tx_idle", TX_WORD, 16'h0000);

        // 2: read burst of three words from 62 with wrap to 0
        DATA_FLAT[62*16 +: 16] = 16'h1111;
        DATA_FLAT[63*16 +: 16] = 16'h2222;
        DATA_FLAT[0*16 +: 16]  = 16'h3333;
        start_frame();
        send_word(16'hFC02);
        check("t2_rd0", TX_WORD, 16'h1111);
        @(negedge SYS_CLK);
        check("t2_rd0_hold", TX_WORD, 16'h1111);
        send_word(16'h0000);
        check("t2_rd1", TX_WORD, 16'h2222);
        send_word(16'hFFFF);
        check("t2_rd2_wrap", TX_WORD, 16'h3333);
        send_word(16'h0000);
        check("t2_rd_end", TX_WORD, 16'h0000);
        check("t2_cmd", CMD_FLAT, exp_cmd);
        end_frame();
        check("t2_err", ERR, 1'b0);

        // 3: write LEN=3 cut short after one word
        start_frame();
        send_word(16'h1403);
        send_word(16'h5555);
        exp_cmd[10*16 +: 16] = 16'h5555;
        end_frame();
        check("t3_cmd", CMD_FLAT, exp_cmd);
        check("t3_err_underrun", ERR, 1'b1);
        clear_err();
        check("t3_err_clr", ERR, 1'b0);
        start_frame();
        send_word(16'h1600);
        send_word(16'h7777);
        exp_cmd[11*16 +: 16] = 16'h7777;
        end_frame();
        check("t3_next_frame", CMD_FLAT, exp_cmd);
        check("t3_err_after", ERR, 1'b0);

        // 4: write LEN=0 followed by an extra word
        start_frame();
        send_word(16'h2800);
        send_word(16'h0A0A);
        exp_cmd[20*16 +: 16] = 16'h0A0A;
        check("t4_err_pre", ERR, 1'b0);
        send_word(16'h0B0B);
        check("t4_err_overrun", ERR, 1'b1);
        check("t4_strobe", CMD_STROBE, 64'h0);
        check("t4_cmd", CMD_FLAT, exp_cmd);
        check("t4_tx", TX_WORD, 16'h0000);
        @(negedge SYS_CLK);
        ERR_CLR  = 1'b1;
        RX_VALID = 1'b1;
        RX_WORD  = 16'h0C0C;
        @(negedge SYS_CLK);
        ERR_CLR  = 1'b0;
        RX_VALID = 1'b0;
        check("t4_err_set_wins", ERR, 1'b1);
        end_frame();
        clear_err();
        check("t4_err_clr", ERR, 1'b0);

        // 5: data word coincident with frame end
        start_frame();
        send_word(16'h3C01);
        @(negedge SYS_CLK);
        RX_VALID     = 1'b1;
        RX_WORD      = 16'h9999;
        FRAME_ACTIVE = 1'b0;
        @(negedge SYS_CLK);
        RX_VALID = 1'b0;
        check("t5_strobe", CMD_STROBE, 64'h0);
        check("t5_cmd", CMD_FLAT, exp_cmd);
        check("t5_err", ERR, 1'b1);
        clear_err();
        start_frame();
        send_word(16'h3C00);
        send_word(16'h4242);
        exp_cmd[30*16 +: 16] = 16'h4242;
        end_frame();
        check("t5_idle_cmd", CMD_FLAT, exp_cmd);
        check("t5_err_after", ERR, 1'b0);

        // 6: reset in the middle of a read burst
        start_frame();
        send_word(16'hFC02);
        send_word(16'h0000);
        check("t6_rd1", TX_WORD, 16'h2222);
        @(negedge SYS_CLK);
        SYS_RST      = 1'b1;
        FRAME_ACTIVE = 1'b0;
        @(negedge SYS_CLK);
        SYS_RST = 1'b0;
        exp_cmd = '0;
        check("t6_tx", TX_WORD, 16'h0000);
        check("t6_cmd", CMD_FLAT, exp_cmd);
        check("t6_err", ERR, 1'b0);
        check("t6_strobe", CMD_STROBE, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
